throw_sequencer: RTL and testbench
==================================

Name: throw_sequencer

Overview:
Game-phase controller for the ball thrower. It sits in front of the angle/power adjuster and the ball-flight datapath.
- Synchronises and debounces the five player buttons.
- Arbitrates adjust requests, with auto-repeat, into single-cycle update strobes for the adjuster.
- Sequences AIM → FLIGHT → HOLD. Adjustments are locked while the ball is in flight.

Parameters:
TICK_DIV, 250000, clk cycles per internal tick (tick = 1-cycle pulse when tick counter reaches TICK_DIV-1)
REPEAT_FIRST, 20, ticks from first adjust strobe to first repeat
REPEAT_NEXT, 5, ticks between subsequent repeats
FLIGHT_TIMEOUT, 1000, ticks in FLIGHT before forced end
HOLD_TICKS, 50, ticks spent in HOLD after landing/timeout
ANG_MAX, 16, upper angle limit; VEL_MAX, 5, upper velocity limit

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
angleup_n, angledown_n, powerup_n, powerdown_n  in  1 each  async buttons, active-low
launch_n  in  1  async launch button, active-low
ang  in  5  current angle from adjuster
vel  in  3  current velocity from adjuster
ball_landed  in  1  level/pulse from flight datapath, sampled every clk
adj_update  out  1  1-cycle adjust strobe
adj_sel  out  2  0=angle up, 1=angle down, 2=power up, 3=power down; valid while adj_update=1
launch_start  out  1  1-cycle launch strobe
phase  out  2  0=AIM, 1=ADJ, 2=FLIGHT, 3=HOLD
flight_busy  out  1  high in FLIGHT

Behaviour:
- Reset clears all outputs, tick counter and repeat/phase counters to 0; phase=AIM.
- Reset mid-flight aborts directly to AIM; no launch_start is issued.
- Each button passes through a 2-flop synchroniser.
- A button is debounced-pressed once it is sampled low on 2 consecutive ticks.
- It is debounced-released on the first tick it is sampled high.
- Eligibility:
  - angle up: ang < ANG_MAX
  - angle down: ang > 0
  - power up: vel < VEL_MAX
  - power down: vel > 0
- Priority among eligible presses: launch > angle up > angle down > power up > power down.
- AIM:
  - Launch pressed: launch_start=1 for one clk, then go to FLIGHT.
  - Else, highest eligible adjust press: adj_update=1 and adj_sel set for one clk, in the cycle after the qualifying tick. Latch the selected button, load repeat count = REPEAT_FIRST, go to ADJ.
- ADJ:
  - Only the latched button is considered; other adjust presses are ignored.
  - Latched button released, or no longer eligible: go to AIM with no strobe.
  - Launch pressed: launch_start, go to FLIGHT; the repeat is abandoned.
  - Each tick decrements the repeat count. When it hits 0: adj_update with the same adj_sel, reload REPEAT_NEXT.
- FLIGHT:
  - flight_busy=1; all adjust and launch presses are ignored.
  - ball_landed=1, or FLIGHT_TIMEOUT ticks elapsed: go to HOLD. ball_landed wins if both occur in the same cycle; the result is identical either way.
- HOLD: after HOLD_TICKS ticks go to AIM. A button still held on entry to AIM acts as a fresh press, with the normal debounce rules.
- adj_update and launch_start are never asserted in the same cycle.
- Counter widths: $clog2 of the parameter value, minimum 1 bit. Counters saturate at 0 and never wrap.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: ADJ repeats as described above.
- Undefined: exactly one adj_update per press. ADJ waits for release or launch only, and the repeat counter is not synthesised.

Test Plan:
All scenarios use TICK_DIV=4, REPEAT_FIRST=3, REPEAT_NEXT=2, FLIGHT_TIMEOUT=10, HOLD_TICKS=2.
- angleup_n held low 40 clk, ang=0 → one adj_update sel=0 after the 2nd low tick, repeats at +3 then every +2 ticks (AUTO_REPEAT_EN). Without the macro, exactly one strobe.
- angleup_n and powerup_n low together, ang=16, vel=2 → angle up ineligible; adj_update sel=2 only.
- launch_n and angledown_n low together, ang=5 → launch_start only, phase=2, no adj_update; angledown presses in FLIGHT are ignored.
- FLIGHT with ball_landed never asserted → HOLD after 10 ticks, AIM 2 ticks later, flight_busy drops on leaving FLIGHT.
- Glitch: powerup_n low for 1 tick only → no strobe. ball_landed pulse in FLIGHT → HOLD next clk.
- rst asserted mid-FLIGHT → next clk phase=0, all outputs 0, and a held launch_n needs a fresh 2-tick debounce.

Source files
------------

// File: rtl/throw_sequencer_if.sv
// Button, adjuster-status and strobe bundle for throw_sequencer.
//   angleup_n/angledown_n/powerup_n/powerdown_n/launch_n : asynchronous buttons, active-low
//   ang[4:0], vel[2:0] : current angle/velocity from the adjuster
//   ball_landed        : landing indication from the flight datapath
//   adj_update/adj_sel : single-cycle adjust strobe and its selector
//   launch_start       : single-cycle launch strobe
//   phase[1:0]         : 0=AIM 1=ADJ 2=FLIGHT 3=HOLD
//   flight_busy        : high while in FLIGHT
// master = environment (drives buttons/status), slave = sequencer.
interface throw_sequencer_if;
    localparam int unsigned ANG_W = 5;
    localparam int unsigned VEL_W = 3;

    logic             angleup_n;
    logic             angledown_n;
    logic             powerup_n;
    logic             powerdown_n;
    logic             launch_n;
    logic [ANG_W-1:0] ang;
    logic [VEL_W-1:0] vel;
    logic             ball_landed;
    logic             adj_update;
    logic [1:0]       adj_sel;
    logic             launch_start;
    logic [1:0]       phase;
    logic             flight_busy;

    modport master (
        output angleup_n, angledown_n, powerup_n, powerdown_n, launch_n,
        output ang, vel, ball_landed,
        input  adj_update, adj_sel, launch_start, phase, flight_busy
    );

    modport slave (
        input  angleup_n, angledown_n, powerup_n, powerdown_n, launch_n,
        input  ang, vel, ball_landed,
        output adj_update, adj_sel, launch_start, phase, flight_busy
    );
endinterface

// File: rtl/throw_sequencer.sv
// Game-phase controller for the ball thrower: synchronises and debounces the
// five buttons, turns adjust presses into single-cycle adjuster strobes and
// sequences AIM -> FLIGHT -> HOLD.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : throw_sequencer_if.slave (buttons, ang/vel, ball_landed in;
//          adj_update/adj_sel, launch_start, phase, flight_busy out)
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held adjust
// button; without it each press yields exactly one adj_update.
module throw_sequencer #(
    parameter int unsigned TICK_DIV       = 250000,
    parameter int unsigned REPEAT_FIRST   = 20,
    parameter int unsigned REPEAT_NEXT    = 5,
    parameter int unsigned FLIGHT_TIMEOUT = 1000,
    parameter int unsigned HOLD_TICKS     = 50,
    parameter int unsigned ANG_MAX        = 16,
    parameter int unsigned VEL_MAX        = 5
) (
    input  logic                clk,
    input  logic                rst,
    throw_sequencer_if.slave    bus
);
    localparam int unsigned ANG_W  = 5;
    localparam int unsigned VEL_W  = 3;
    localparam int unsigned N_BTN  = 5;
    localparam int unsigned LAUNCH = 4;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PH_MAX = (FLIGHT_TIMEOUT > HOLD_TICKS) ? FLIGHT_TIMEOUT : HOLD_TICKS;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
`endif

    typedef enum logic [1:0] {
        AIM    = 2'd0,
        ADJ    = 2'd1,
        FLIGHT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Button index equals adj_sel encoding; launch sits above the adjust buttons.
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] seen_low;
    logic [N_BTN-1:0] held;
    logic [N_BTN-1:0] held_d;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    logic [3:0]        elig;
    logic [3:0]        cand;
    logic              cand_any;
    logic [1:0]        cand_sel;
    logic              lost;

    state_t            state, state_d;
    logic [1:0]        lat_sel, lat_sel_d;
    logic [PH_W-1:0]   phase_cnt, phase_cnt_d;
`ifdef AUTO_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt, rep_cnt_d;
`endif
    logic              adj_update_q, adj_update_d;
    logic [1:0]        adj_sel_q, adj_sel_d;
    logic              launch_start_q, launch_start_d;
    logic              flight_busy_q, flight_busy_d;

    assign btn_raw = {bus.launch_n, bus.powerdown_n, bus.powerup_n, bus.angledown_n, bus.angleup_n};

    // Two-flop synchronisers; reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Internal tick generator.
    assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Debounce: pressed after two consecutive low tick samples, released on the
    // first high one. held_d is the state as of this cycle's tick, so the FSM
    // can react in the same cycle as the qualifying tick.
    assign held_d = tick_c ? (~sync2 & seen_low) : held;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_low <= '0;
            held     <= '0;
        end else if (tick_c) begin
            seen_low <= ~sync2;
            held     <= held_d;
        end
    end

    // Eligibility per adjust direction, bit index = adj_sel.
    assign elig = {bus.vel != '0, bus.vel < VEL_W'(VEL_MAX),
                   bus.ang != '0, bus.ang < ANG_W'(ANG_MAX)};
    assign cand     = held_d[3:0] & elig;
    assign cand_any = |cand;

    // Lowest index wins among eligible adjust presses.
    always_comb begin
        cand_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) cand_sel = 2'(i);
        end
    end

`ifdef AUTO_REPEAT_EN
    assign lost = !elig[lat_sel];
`else
    assign lost = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= AIM;
            lat_sel        <= 2'd0;
            phase_cnt      <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt        <= '0;
`endif
            adj_update_q   <= 1'b0;
            adj_sel_q      <= 2'd0;
            launch_start_q <= 1'b0;
            flight_busy_q  <= 1'b0;
        end else begin
            state          <= state_d;
            lat_sel        <= lat_sel_d;
            phase_cnt      <= phase_cnt_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt        <= rep_cnt_d;
`endif
            adj_update_q   <= adj_update_d;
            adj_sel_q      <= adj_sel_d;
            launch_start_q <= launch_start_d;
            flight_busy_q  <= flight_busy_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state;
        lat_sel_d      = lat_sel;
        phase_cnt_d    = phase_cnt;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d      = rep_cnt;
`endif
        adj_update_d   = 1'b0;
        adj_sel_d      = 2'd0;
        launch_start_d = 1'b0;

        case (state)
            AIM: begin
                if (tick_c) begin
                    if (held_d[LAUNCH]) begin
                        launch_start_d = 1'b1;
                        phase_cnt_d    = PH_W'(FLIGHT_TIMEOUT - 1);
                        state_d        = FLIGHT;
                    end else if (cand_any) begin
                        adj_update_d = 1'b1;
                        adj_sel_d    = cand_sel;
                        lat_sel_d    = cand_sel;
`ifdef AUTO_REPEAT_EN
                        rep_cnt_d    = REP_W'(REPEAT_FIRST - 1);
`endif
                        state_d      = ADJ;
                    end
                end
            end
            ADJ: begin
                if (lost) begin
                    state_d = AIM;
                end else if (tick_c) begin
                    if (held_d[LAUNCH]) begin
                        launch_start_d = 1'b1;
                        phase_cnt_d    = PH_W'(FLIGHT_TIMEOUT - 1);
                        state_d        = FLIGHT;
                    end else if (!held_d[lat_sel]) begin
                        state_d = AIM;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_cnt == '0) begin
                        adj_update_d = 1'b1;
                        adj_sel_d    = lat_sel;
                        rep_cnt_d    = REP_W'(REPEAT_NEXT - 1);
                    end else begin
                        rep_cnt_d = rep_cnt - REP_W'(1);
                    end
`endif
                end
            end
            FLIGHT: begin
                // Landing and timeout lead to the same HOLD entry.
                if (bus.ball_landed || (tick_c && phase_cnt == '0)) begin
                    phase_cnt_d = PH_W'(HOLD_TICKS - 1);
                    state_d     = HOLD;
                end else if (tick_c) begin
                    phase_cnt_d = phase_cnt - PH_W'(1);
                end
            end
            HOLD: begin
                if (tick_c) begin
                    if (phase_cnt == '0) begin
                        state_d = AIM;
                    end else begin
                        phase_cnt_d = phase_cnt - PH_W'(1);
                    end
                end
            end
            default: state_d = AIM;
        endcase

        flight_busy_d = (state_d == FLIGHT);
    end

    assign bus.adj_update   = adj_update_q;
    assign bus.adj_sel      = adj_sel_q;
    assign bus.launch_start = launch_start_q;
    assign bus.phase        = 2'(state);
    assign bus.flight_busy  = flight_busy_q;
endmodule

// File: tb/tb_throw_sequencer.sv
// Directed bench for throw_sequencer with TICK_DIV=4, REPEAT_FIRST=3,
// REPEAT_NEXT=2, FLIGHT_TIMEOUT=10, HOLD_TICKS=2. cyc counts posedges after
// reset release; outputs are sampled 1 time unit after each posedge.
module tb_throw_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    throw_sequencer_if bus();

    throw_sequencer #(
        .TICK_DIV      (4),
        .REPEAT_FIRST  (3),
        .REPEAT_NEXT   (2),
        .FLIGHT_TIMEOUT(10),
        .HOLD_TICKS    (2),
        .ANG_MAX       (16),
        .VEL_MAX       (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc;
    int n_pass;
    int n_fail;
    int n_total;
    int n_adj;
    int n_launch;
    int n_both;
    int last_sel;
    int last_launch;
    int base_adj;
    int adj_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to a given cycle, logging strobes as they appear.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.adj_update === 1'b1) begin
                n_adj++;
                last_sel = 32'(bus.adj_sel);
                adj_cyc.push_back(cyc);
            end
            if (bus.launch_start === 1'b1) begin
                n_launch++;
                last_launch = cyc;
            end
            if (bus.adj_update === 1'b1 && bus.launch_start === 1'b1) n_both++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.angleup_n = 1'b1;
        bus.angledown_n = 1'b1;
        bus.powerup_n = 1'b1;
        bus.powerdown_n = 1'b1;
        bus.launch_n = 1'b1;
        bus.ang = 5'd0;
        bus.vel = 3'd0;
        bus.ball_landed = 1'b0;
        cyc = 0; n_pass = 0; n_fail = 0; n_total = 0;
        n_adj = 0; n_launch = 0; n_both = 0; last_sel = -1; last_launch = -1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_adj_update", 32'(bus.adj_update), 0);
        check("rst_adj_sel", 32'(bus.adj_sel), 0);
        check("rst_launch_start", 32'(bus.launch_start), 0);
        check("rst_phase", 32'(bus.phase), 0);
        check("rst_flight_busy", 32'(bus.flight_busy), 0);

        // Angle up held from release of reset, ang=0.
        @(negedge clk);
        rst = 1'b0;
        bus.angleup_n = 1'b0;
        run_to(7);
        check("s1_no_early_strobe", n_adj, 0);
        run_to(8);
        check("s1_first_strobe", n_adj, 1);
        check("s1_first_sel", 32'(bus.adj_sel), 0);
        run_to(9);
        check("s1_phase_adj", 32'(bus.phase), 1);
        run_to(40);
        @(negedge clk);
        bus.angleup_n = 1'b1;
        run_to(43);
        check("s1_phase_still_adj", 32'(bus.phase), 1);
        run_to(44);
        check("s1_phase_aim_on_release", 32'(bus.phase), 0);
        run_to(48);
`ifdef AUTO_REPEAT_EN
        check("s1_strobe_count", n_adj, 4);
        check("s1_repeat1_cyc", adj_cyc[1], 20);
        check("s1_repeat2_cyc", adj_cyc[2], 28);
        check("s1_repeat3_cyc", adj_cyc[3], 36);
`else
        check("s1_strobe_count", n_adj, 1);
`endif

        // Angle up and power up together, angle at its limit.
        @(negedge clk);
        bus.ang = 5'd16;
        bus.vel = 3'd2;
        bus.angleup_n = 1'b0;
        bus.powerup_n = 1'b0;
        base_adj = n_adj;
        run_to(56);
        check("s2_strobe_count", n_adj - base_adj, 1);
        check("s2_sel_power_up", last_sel, 2);
        check("s2_phase_adj", 32'(bus.phase), 1);
        run_to(60);
        @(negedge clk);
        bus.angleup_n = 1'b1;
        bus.powerup_n = 1'b1;
        run_to(64);
        check("s2_phase_aim", 32'(bus.phase), 0);
        check("s2_no_extra_strobe", n_adj - base_adj, 1);

        // Launch together with angle down; flight ends by timeout.
        @(negedge clk);
        bus.ang = 5'd5;
        bus.launch_n = 1'b0;
        bus.angledown_n = 1'b0;
        base_adj = n_adj;
        run_to(72);
        check("s3_launch_count", n_launch, 1);
        check("s3_launch_cyc", last_launch, 72);
        check("s3_phase_flight", 32'(bus.phase), 2);
        check("s3_flight_busy", 32'(bus.flight_busy), 1);
        run_to(80);
        @(negedge clk);
        bus.launch_n = 1'b1;
        bus.angledown_n = 1'b1;
        run_to(111);
        check("s4_phase_flight_last", 32'(bus.phase), 2);
        check("s4_busy_last", 32'(bus.flight_busy), 1);
        check("s3_no_adj_in_flight", n_adj - base_adj, 0);
        run_to(112);
        check("s4_phase_hold", 32'(bus.phase), 3);
        check("s4_busy_dropped", 32'(bus.flight_busy), 0);
        run_to(119);
        check("s4_phase_hold_last", 32'(bus.phase), 3);
        run_to(120);
        check("s4_phase_aim", 32'(bus.phase), 0);
        check("s4_single_launch", n_launch, 1);

        // Power up glitch lasting a single tick sample.
        @(negedge clk);
        bus.powerup_n = 1'b0;
        run_to(124);
        @(negedge clk);
        bus.powerup_n = 1'b1;
        run_to(136);
        check("s5_glitch_no_strobe", n_adj - base_adj, 0);
        check("s5_phase_aim", 32'(bus.phase), 0);

        // Launch, then a one-cycle ball_landed pulse.
        @(negedge clk);
        bus.launch_n = 1'b0;
        run_to(144);
        check("s5_launch_cyc", last_launch, 144);
        @(negedge clk);
        bus.launch_n = 1'b1;
        run_to(150);
        check("s5_phase_flight", 32'(bus.phase), 2);
        @(negedge clk);
        bus.ball_landed = 1'b1;
        run_to(151);
        check("s5_landed_hold", 32'(bus.phase), 3);
        check("s5_landed_busy", 32'(bus.flight_busy), 0);
        @(negedge clk);
        bus.ball_landed = 1'b0;
        run_to(156);
        check("s5_back_to_aim", 32'(bus.phase), 0);

        // Reset in the middle of a flight with launch still held.
        @(negedge clk);
        bus.launch_n = 1'b0;
        run_to(164);
        check("s6_launch_cyc", last_launch, 164);
        check("s6_launch_count", n_launch, 3);
        run_to(170);
        @(negedge clk);
        rst = 1'b1;
        run_to(171);
        check("s6_rst_phase", 32'(bus.phase), 0);
        check("s6_rst_busy", 32'(bus.flight_busy), 0);
        check("s6_rst_launch", 32'(bus.launch_start), 0);
        check("s6_rst_adj", 32'(bus.adj_update), 0);
        check("s6_rst_sel", 32'(bus.adj_sel), 0);
        @(negedge clk);
        rst = 1'b0;
        run_to(178);
        check("s6_no_launch_before_debounce", n_launch, 3);
        run_to(179);
        check("s6_relaunch_count", n_launch, 4);
        check("s6_relaunch_cyc", last_launch, 179);
        check("s6_relaunch_phase", 32'(bus.phase), 2);
        @(negedge clk);
        bus.launch_n = 1'b1;
        run_to(184);

        check("never_both_strobes", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
